// File: rtl/valve_sequencer.sv
// Inlet valve sequencer: opens one inlet valve for a programmed fill time, with an
// all-closed dead time before opening and an optional settle with the trap outlet open.
module valve_sequencer #(
    parameter int N_CH       = 2,
    parameter int CNT_W      = 16,
    parameter int DEAD_CYC   = 2,
    parameter int SETTLE_CYC = 4,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [CNT_W-1:0]  fill_cyc,
    input  logic              abort,
    output logic [N_CH-1:0]   valve_cp,
    output logic              trap_cp,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // state  | meaning
    // IDLE   | all valves closed, trap closed, waiting for start
    // DEAD   | all valves closed, trap closed, break-before-make gap
    // FILL   | selected valve open, trap open
    // SETTLE | all valves closed, trap open to let the node settle

    localparam int TC_W = (CNT_W > 8) ? CNT_W : 8;

    typedef enum logic [1:0] {IDLE, DEAD, FILL, SETTLE} state_t;

    state_t            state, state_nxt;
    logic [TC_W-1:0]   cnt, cnt_nxt;
    logic [CH_W-1:0]   ch_reg, ch_nxt;
    logic [CNT_W-1:0]  fill_reg, fill_nxt;
    logic              done_nxt, err_nxt;
    logic              req_ok;

    assign req_ok = (32'(ch_sel) < 32'(N_CH)) && (fill_cyc != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ch_reg   <= '0;
            fill_reg <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ch_reg   <= ch_nxt;
            fill_reg <= fill_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
        end
    end

    // Phase counter is a down-counter loaded with (length - 1); expiry at zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ch_nxt    = ch_reg;
        fill_nxt  = fill_reg;
        done_nxt  = 1'b0;
        err_nxt   = err;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    ch_nxt   = ch_sel;
                    fill_nxt = fill_cyc;
                    if (req_ok) begin
                        state_nxt = DEAD;
                        cnt_nxt   = TC_W'(DEAD_CYC - 1);
                        err_nxt   = 1'b0;
                    end else begin
                        err_nxt  = 1'b1;
                        done_nxt = 1'b1;
                    end
                end
            end
            DEAD: begin
                if (cnt == '0) begin
                    state_nxt = FILL;
                    cnt_nxt   = TC_W'(fill_reg) - TC_W'(1);
                end else begin
                    cnt_nxt = cnt - TC_W'(1);
                end
            end
            FILL: begin
                if (cnt == '0) begin
                    if (SETTLE_CYC == 0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = SETTLE;
                        cnt_nxt   = TC_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
                    end
                end else begin
                    cnt_nxt = cnt - TC_W'(1);
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - TC_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Abort wins over expiry; err keeps its last value.
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            done_nxt  = 1'b0;
        end
    end

    always_comb begin
        valve_cp = '1;
        if (state == FILL) valve_cp[ch_reg] = 1'b0;
        trap_cp = !(state == FILL || state == SETTLE);
        busy    = (state != IDLE);
    end

endmodule

// File: tb/tb_valve_sequencer.sv
// Bench for valve_sequencer: directed literal scenarios plus randomized traffic
// checked every cycle against a sequence-timeline model and safety invariants.
module tb_valve_sequencer;
    localparam int NC = 4;
    localparam int D  = 2;
    localparam int S  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0;
    logic [1:0] ch_sel = '0;
    logic [7:0] fill_cyc = '0;
    logic [3:0] valve_cp;
    logic       trap_cp, busy, done, err;

    logic       start3 = 1'b0;
    logic [1:0] ch3 = '0;
    logic [7:0] fill3 = '0;
    logic [2:0] valve3;
    logic       trap3, busy3, done3, err3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    valve_sequencer #(.N_CH(NC), .CNT_W(8), .DEAD_CYC(D), .SETTLE_CYC(S)) dut (
        .clk(clk), .rst(rst), .start(start), .ch_sel(ch_sel), .fill_cyc(fill_cyc),
        .abort(abort), .valve_cp(valve_cp), .trap_cp(trap_cp), .busy(busy),
        .done(done), .err(err));

    valve_sequencer #(.N_CH(3), .CNT_W(8), .DEAD_CYC(D), .SETTLE_CYC(0)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .ch_sel(ch3), .fill_cyc(fill3),
        .abort(1'b0), .valve_cp(valve3), .trap_cp(trap3), .busy(busy3),
        .done(done3), .err(err3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: m_t is the 1-based position inside the active sequence.
    bit m_act, m_done, m_err;
    int m_t, m_ch, m_fill;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 0; m_done = 0; m_err = 0; m_t = 0; m_ch = 0; m_fill = 0;
        end else if (m_act) begin
            if (abort) begin
                m_act = 0; m_done = 0;
            end else if (m_t == D + m_fill + S) begin
                m_act = 0; m_done = 1;
            end else begin
                m_t++; m_done = 0;
            end
        end else begin
            m_done = 0;
            if (start && !abort) begin
                if (fill_cyc != 0) begin
                    m_act = 1; m_t = 1; m_ch = int'(ch_sel); m_fill = int'(fill_cyc); m_err = 0;
                end else begin
                    m_err = 1; m_done = 1;
                end
            end
        end
    end

    function automatic logic [3:0] exp_valve();
        logic [3:0] one;
        one = 4'b0001;
        if (m_act && m_t > D && m_t <= D + m_fill) return ~(one << m_ch);
        return 4'b1111;
    endfunction

    int closed_run = 0;
    logic [3:0] prev_valve = 4'b1111;

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_busy",  32'(busy),     32'(m_act));
            chk("m_valve", 32'(valve_cp), 32'(exp_valve()));
            chk("m_trap",  32'(trap_cp),  32'(!(m_act && m_t > D)));
            chk("m_done",  32'(done),     32'(m_done));
            chk("m_err",   32'(err),      32'(m_err));
            chk("inv_one_open", 32'($countones(~valve_cp) <= 1), 32'd1);
            if (valve_cp != 4'b1111 && prev_valve == 4'b1111)
                chk("inv_dead_before_open", 32'(closed_run >= D), 32'd1);
            closed_run = (valve_cp == 4'b1111) ? closed_run + 1 : 0;
            prev_valve = valve_cp;
        end
    end

    initial begin
        #12;
        chk("rst_valve", 32'(valve_cp), 32'hF);
        chk("rst_trap",  32'(trap_cp),  32'd1);
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_done",  32'(done),     32'd0);
        chk("rst_err",   32'(err),      32'd0);

        // Nominal, with start applied on the first edge after reset release.
        @(negedge clk); rst = 0; start = 1; ch_sel = 2; fill_cyc = 5;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk("nom_busy",  32'(busy),     32'(c <= 10));
            chk("nom_valve", 32'(valve_cp), (c >= 3 && c <= 7) ? 32'hB : 32'hF);
            chk("nom_trap",  32'(trap_cp),  32'(!(c >= 3 && c <= 10)));
            chk("nom_done",  32'(done),     32'(c == 11));
            if (c == 1) begin start = 0; ch_sel = 1; fill_cyc = 9; end
            if (c == 4) start = 1;
            if (c == 6) start = 0;
        end

        // Reject: zero fill length.
        start = 1; ch_sel = 0; fill_cyc = 0;
        @(negedge clk);
        chk("rej0_err",   32'(err),      32'd1);
        chk("rej0_done",  32'(done),     32'd1);
        chk("rej0_valve", 32'(valve_cp), 32'hF);
        start = 0;
        @(negedge clk);
        chk("rej0_done_clr", 32'(done), 32'd0);
        chk("rej0_valve2",   32'(valve_cp), 32'hF);

        // Reject on the 3-channel instance: channel out of range.
        start3 = 1; ch3 = 3; fill3 = 4;
        @(negedge clk);
        chk("rej3_err",   32'(err3),   32'd1);
        chk("rej3_done",  32'(done3),  32'd1);
        chk("rej3_valve", 32'(valve3), 32'h7);
        chk("rej3_busy",  32'(busy3),  32'd0);
        start3 = 0;
        @(negedge clk);
        chk("rej3_done_clr", 32'(done3),  32'd0);
        chk("rej3_valve2",   32'(valve3), 32'h7);

        // Zero settle: FILL returns straight to IDLE.
        start3 = 1; ch3 = 2; fill3 = 3;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start3 = 0;
            chk("s0_busy",  32'(busy3),  32'(c <= 5));
            chk("s0_valve", 32'(valve3), (c >= 3 && c <= 5) ? 32'h3 : 32'h7);
            chk("s0_trap",  32'(trap3),  32'(!(c >= 3 && c <= 5)));
            chk("s0_done",  32'(done3),  32'(c == 6));
            chk("s0_err",   32'(err3),   32'd0);
        end

        // Abort in the second FILL cycle.
        start = 1; ch_sel = 1; fill_cyc = 4;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) start = 0;
            if (c == 3 || c == 4) chk("ab_valve_open", 32'(valve_cp), 32'hD);
            if (c >= 5) begin
                chk("ab_valve", 32'(valve_cp), 32'hF);
                chk("ab_trap",  32'(trap_cp),  32'd1);
                chk("ab_busy",  32'(busy),     32'd0);
                chk("ab_done",  32'(done),     32'd0);
                chk("ab_err",   32'(err),      32'd0);
            end
            abort = (c == 4);
        end

        // Start while busy is dropped; start in the done cycle chains a new sequence.
        start = 1; ch_sel = 3; fill_cyc = 2;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 3 || c == 4) chk("cc_valve_a", 32'(valve_cp), 32'h7);
            if (c == 8) begin
                chk("cc_done", 32'(done), 32'd1);
                chk("cc_busy", 32'(busy), 32'd0);
            end
            if (c == 9 || c == 10) begin
                chk("cc_dead_busy",  32'(busy),     32'd1);
                chk("cc_dead_valve", 32'(valve_cp), 32'hF);
            end
            if (c == 11) chk("cc_valve_b", 32'(valve_cp), 32'hE);
            start = (c == 2 || c == 8);
            if (c == 2) begin ch_sel = 0; fill_cyc = 3; end
        end

        // Asynchronous reset between edges, mid-FILL.
        start = 1; ch_sel = 2; fill_cyc = 5;
        @(negedge clk); start = 0;
        @(negedge clk);
        @(negedge clk);
        chk("ar_pre_fill", 32'(valve_cp), 32'hB);
        @(posedge clk); #2 rst = 1; #1;
        chk("ar_valve", 32'(valve_cp), 32'hF);
        chk("ar_trap",  32'(trap_cp),  32'd1);
        chk("ar_busy",  32'(busy),     32'd0);
        chk("ar_done",  32'(done),     32'd0);
        @(negedge clk); rst = 0;

        // Randomized traffic, checked by the model process.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 3) == 0);
            ch_sel   = 2'($urandom);
            fill_cyc = 8'($urandom_range(0, 7));
            abort    = ($urandom_range(0, 24) == 0);
        end
        @(negedge clk); start = 0; abort = 0;
        repeat (30) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/valve_sequencer.md
VALVE_SEQUENCER -- requirements
Module: valve_sequencer

Interface
REQ-001 The block SHALL have parameter N_CH, default 2: number of inlet valves feeding the trap node, legal range 2..16.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the fill duration field.
REQ-003 The block SHALL have parameter DEAD_CYC, default 2: all-closed cycles before a valve opens, legal range 1..255.
REQ-004 The block SHALL have parameter SETTLE_CYC, default 4: post-fill cycles with the trap outlet open, legal range 0..255.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: request one fill sequence.
REQ-008 The block SHALL have port ch_sel, input, max(1,clog2(N_CH)) bits: selects the inlet channel.
REQ-009 The block SHALL have port fill_cyc, input, CNT_W bits: valve-open duration in cycles.
REQ-010 The block SHALL have port abort, input, 1 bit: terminate the active sequence.
REQ-011 The block SHALL have port valve_cp, output, N_CH bits: control-port pressure per inlet valve; 1 = pressurised = closed.
REQ-012 The block SHALL have port trap_cp, output, 1 bit: trap outlet control port; 1 = closed.
REQ-013 The block SHALL have port busy, output, 1 bit: a sequence is active.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse on sequence completion.
REQ-015 The block SHALL have port err, output, 1 bit: last request was rejected.

Function
REQ-016 The block SHALL implement states IDLE, DEAD, FILL and SETTLE.
REQ-017 In IDLE with abort=0, start=1 SHALL be sampled and ch_sel and fill_cyc captured into registers.
- Valid request (ch_sel<N_CH, fill_cyc!=0): next state DEAD, busy=1, err=0.
- Invalid request: state stays IDLE, err=1, done=1 for one cycle, no valve opens.
REQ-018 DEAD SHALL last exactly DEAD_CYC cycles with valve_cp all ones and trap_cp=1.
REQ-019 FILL SHALL last exactly the captured fill_cyc cycles with valve_cp[ch]=0, all other valve_cp bits 1, and trap_cp=0.
REQ-020 SETTLE SHALL last SETTLE_CYC cycles with all valves closed and trap_cp=0; SETTLE_CYC=0 SHALL go directly FILL->IDLE.
REQ-021 On the first IDLE cycle after FILL or SETTLE, done SHALL be 1 for exactly one cycle, busy=0, and trap_cp=1.
REQ-022 Total busy duration SHALL be DEAD_CYC+fill_cyc+SETTLE_CYC cycles.
REQ-023 start while busy=1 SHALL be ignored and not queued.
REQ-024 start in the cycle done=1 SHALL be accepted, giving back-to-back sequences that still include the DEAD phase.
REQ-025 abort=1 in any non-IDLE state SHALL, next cycle, force IDLE: all valves closed, trap_cp=1, busy=0, done=0, err unchanged.
REQ-026 abort SHALL take priority over phase-counter expiry in the same cycle, and over start in IDLE (start dropped).
REQ-027 Invariant: at most one valve_cp bit SHALL be 0 in any cycle.
REQ-028 Invariant: a valve SHALL never open without at least DEAD_CYC preceding all-closed cycles.
REQ-029 Changes to ch_sel and fill_cyc during busy SHALL have no effect on the active sequence.

Reset
REQ-030 While rst=1, asynchronously and regardless of clk: state=IDLE, valve_cp all ones, trap_cp=1, busy=0, done=0, err=0, and all counters cleared.
REQ-031 The first start SHALL be honoured on the first rising edge after rst deasserts.

Verification (N_CH=4, CNT_W=8, DEAD_CYC=2, SETTLE_CYC=3 unless noted)
REQ-032 Reset: assert rst mid-FILL between clock edges -> valve_cp=4'b1111, trap_cp=1, busy=0 immediately, before the next edge.
REQ-033 Nominal: start with ch_sel=2, fill_cyc=5 at edge 0 ->
- busy=1 for cycles 1-10.
- valve_cp=4'b1011 exactly in cycles 3-7.
- trap_cp=0 in cycles 3-10.
- done=1 only in cycle 11.
REQ-034 Reject: fill_cyc=0 -> err=1, one done pulse, valve_cp stays 4'b1111.
REQ-035 Reject: N_CH=3 instance with ch_sel=3 -> err=1, one done pulse, valve_cp stays 3'b111.
REQ-036 Abort: abort in the 2nd FILL cycle -> next cycle valve_cp=4'b1111, trap_cp=1, busy=0, no done pulse.
REQ-037 Concurrency:
- start during busy -> ignored.
- start in the done cycle with ch_sel=0 -> DEAD 2 cycles, then valve_cp=4'b1110.
- The bench SHALL check REQ-027 and REQ-028 every cycle.
